// File: rtl/traffic_pkg.sv
// Shared types and encodings for the traffic-light sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RED,
    ST_GREEN,
    ST_AMBER,
    ST_FLASH,
    ST_ALLRED
  } state_t;

  localparam logic [1:0] PH_RED      = 2'd0;
  localparam logic [1:0] PH_GREEN    = 2'd1;
  localparam logic [1:0] PH_AMBER    = 2'd2;
  localparam logic [1:0] PH_OVERRIDE = 2'd3;

  localparam logic [1:0] MODE_DAY    = 2'b00;
  localparam logic [1:0] MODE_NIGHT  = 2'b01;
  localparam logic [1:0] MODE_FLASH  = 2'b10;
  localparam logic [1:0] MODE_ALLRED = 2'b11;

  function automatic logic is_cycling(input state_t s);
    return (s == ST_RED) || (s == ST_GREEN) || (s == ST_AMBER);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: clears to zero or increments each cycle; flags cnt == last.
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt_nxt = i_clear ? '0 : r_cnt + CNT_W'(1);
  assign o_tc      = (r_cnt == i_last);

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else          r_cnt <= o_cnt_nxt;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer: RED -> GREEN -> AMBER cycle with blink warning,
// amber-flash and all-red overrides.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned RED_TICS_DAY     = 350,
  parameter int unsigned GREEN_TICS_DAY   = 350,
  parameter int unsigned RED_TICS_NIGHT   = 200,
  parameter int unsigned GREEN_TICS_NIGHT = 200,
  parameter int unsigned AMBER_TICS       = 30,
  parameter int unsigned FLASH_TICS       = 50,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] mode,
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic [1:0] phase,
  output logic       phase_done
);

  localparam longint unsigned L_LIM = 64'd1 << CNT_W;
  localparam bit L_BAD =
      (RED_TICS_DAY < 4) || (GREEN_TICS_DAY < 4) || (RED_TICS_NIGHT < 4) ||
      (GREEN_TICS_NIGHT < 4) || (AMBER_TICS < 4) || (FLASH_TICS < 1) ||
      (longint'(RED_TICS_DAY) >= L_LIM) || (longint'(GREEN_TICS_DAY) >= L_LIM) ||
      (longint'(RED_TICS_NIGHT) >= L_LIM) || (longint'(GREEN_TICS_NIGHT) >= L_LIM) ||
      (longint'(AMBER_TICS) >= L_LIM) || (longint'(FLASH_TICS) >= L_LIM);

  if (L_BAD) begin : g_bad_params
    $error("traffic_light_ctrl: phase lengths must be >= 4 (FLASH_TICS >= 1) and < 2**CNT_W");
  end

  // Terminal counts (T-1) per phase.
  localparam logic [CNT_W-1:0] L_RED_DAY     = CNT_W'(RED_TICS_DAY - 1);
  localparam logic [CNT_W-1:0] L_GREEN_DAY   = CNT_W'(GREEN_TICS_DAY - 1);
  localparam logic [CNT_W-1:0] L_RED_NIGHT   = CNT_W'(RED_TICS_NIGHT - 1);
  localparam logic [CNT_W-1:0] L_GREEN_NIGHT = CNT_W'(GREEN_TICS_NIGHT - 1);
  localparam logic [CNT_W-1:0] L_AMBER       = CNT_W'(AMBER_TICS - 1);
  localparam logic [CNT_W-1:0] L_FLASH       = CNT_W'(FLASH_TICS - 1);

  function automatic logic [CNT_W-1:0] last_of(input state_t s, input logic night);
    case (s)
      ST_RED:   return night ? L_RED_NIGHT : L_RED_DAY;
      ST_GREEN: return night ? L_GREEN_NIGHT : L_GREEN_DAY;
      ST_AMBER: return L_AMBER;
      ST_FLASH: return L_FLASH;
      default:  return '0;
    endcase
  endfunction

  // Lamp lit for cnt < T-3 and at T-2; dark at T-3 and T-1.
  function automatic logic blink_lit(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] l);
    return (c < l - CNT_W'(2)) || (c == l - CNT_W'(1));
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_night, w_night_nxt;
  logic             r_flash_lit, w_flash_lit_nxt;
  logic             w_clear, w_tc;
  logic [CNT_W-1:0] w_last, w_last_nxt, w_cnt_nxt;
  logic             w_red_nxt, w_amber_nxt, w_green_nxt, w_done_nxt;
  logic [1:0]       w_phase_nxt;

  assign w_last = last_of(r_state, r_night);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .i_last   (w_last),
    .o_cnt_nxt(w_cnt_nxt),
    .o_tc     (w_tc)
  );

  // State, latched cycling mode and flash half-period register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_night     <= 1'b0;
      r_flash_lit <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_night     <= w_night_nxt;
      r_flash_lit <= w_flash_lit_nxt;
    end
  end

  // Next-state: override requests win over phase progression.
  always_comb begin
    w_state_nxt     = r_state;
    w_night_nxt     = r_night;
    w_flash_lit_nxt = r_flash_lit;
    w_clear         = 1'b0;
    case (r_state)
      ST_RED, ST_GREEN, ST_AMBER: begin
        if (mode == MODE_FLASH) begin
          w_state_nxt     = ST_FLASH;
          w_flash_lit_nxt = 1'b1;
          w_clear         = 1'b1;
        end else if (mode == MODE_ALLRED) begin
          w_state_nxt = ST_ALLRED;
          w_clear     = 1'b1;
        end else if (w_tc) begin
          w_clear = 1'b1;
          if (r_state == ST_RED) begin
            w_state_nxt = ST_GREEN;
          end else if (r_state == ST_GREEN) begin
            w_state_nxt = ST_AMBER;
          end else begin
            w_state_nxt = ST_RED;
            w_night_nxt = (mode == MODE_NIGHT);
          end
        end
      end
      ST_FLASH: begin
        if (mode == MODE_FLASH) begin
          if (w_tc) begin
            w_clear         = 1'b1;
            w_flash_lit_nxt = ~r_flash_lit;
          end
        end else if (mode == MODE_ALLRED) begin
          w_state_nxt = ST_ALLRED;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = ST_RED;
          w_night_nxt = (mode == MODE_NIGHT);
          w_clear     = 1'b1;
        end
      end
      default: begin
        // IDLE and ALLRED: counter held at zero until the next phase starts.
        w_clear = 1'b1;
        if (mode == MODE_FLASH) begin
          w_state_nxt     = ST_FLASH;
          w_flash_lit_nxt = 1'b1;
        end else if (mode == MODE_ALLRED) begin
          w_state_nxt = ST_ALLRED;
        end else begin
          w_state_nxt = ST_RED;
          w_night_nxt = (mode == MODE_NIGHT);
        end
      end
    endcase
  end

  // Output decode from the next state/count so lamps align with phase.
  always_comb begin
    w_red_nxt   = 1'b0;
    w_amber_nxt = 1'b0;
    w_green_nxt = 1'b0;
    w_phase_nxt = PH_RED;
    w_last_nxt  = last_of(w_state_nxt, w_night_nxt);
    w_done_nxt  = is_cycling(w_state_nxt) && (w_cnt_nxt == w_last_nxt);
    case (w_state_nxt)
      ST_RED: begin
        w_red_nxt   = blink_lit(w_cnt_nxt, w_last_nxt);
        w_phase_nxt = PH_RED;
      end
      ST_GREEN: begin
        w_green_nxt = blink_lit(w_cnt_nxt, w_last_nxt);
        w_phase_nxt = PH_GREEN;
      end
      ST_AMBER: begin
        w_amber_nxt = blink_lit(w_cnt_nxt, w_last_nxt);
        w_phase_nxt = PH_AMBER;
      end
      ST_FLASH: begin
        w_amber_nxt = w_flash_lit_nxt;
        w_phase_nxt = PH_OVERRIDE;
      end
      ST_ALLRED: begin
        w_red_nxt   = 1'b1;
        w_phase_nxt = PH_OVERRIDE;
      end
      default: ;
    endcase
  end

  // Registered lamp and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      red        <= 1'b0;
      amber      <= 1'b0;
      green      <= 1'b0;
      phase      <= PH_RED;
      phase_done <= 1'b0;
    end else begin
      red        <= w_red_nxt;
      amber      <= w_amber_nxt;
      green      <= w_green_nxt;
      phase      <= w_phase_nxt;
      phase_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios then random
// mode changes, compared against a phase/elapsed-time reference model.
module tb_traffic_light_ctrl;

  localparam int unsigned RD = 8, GD = 6, RN = 5, GN = 4, AT = 4, FT = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       red, amber, green, phase_done;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_ctrl #(
    .RED_TICS_DAY    (RD),
    .GREEN_TICS_DAY  (GD),
    .RED_TICS_NIGHT  (RN),
    .GREEN_TICS_NIGHT(GN),
    .AMBER_TICS      (AT),
    .FLASH_TICS      (FT),
    .CNT_W           (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .phase     (phase),
    .phase_done(phase_done)
  );

  always #5 clock = ~clock;

  // Reference model: activity kind, cycling phase index, elapsed cycles.
  // kind: 0 idle, 1 cycling, 2 amber flash, 3 all-red
  int m_kind = 0;
  int m_ph   = 0;
  int m_t    = 0;
  bit m_night = 1'b0;

  function automatic int plen(input int ph, input bit night);
    if (ph == 0) return night ? RN : RD;
    if (ph == 1) return night ? GN : GD;
    return AT;
  endfunction

  task automatic model_enter(input logic [1:0] md);
    m_t = 0;
    if (md == 2'b10) m_kind = 2;
    else if (md == 2'b11) m_kind = 3;
    else begin
      m_kind  = 1;
      m_ph    = 0;
      m_night = (md == 2'b01);
    end
  endtask

  task automatic model_edge(input logic [1:0] md);
    case (m_kind)
      1: begin
        if (md[1]) model_enter(md);
        else if (m_t == plen(m_ph, m_night) - 1) begin
          m_t  = 0;
          m_ph = (m_ph + 1) % 3;
          if (m_ph == 0) m_night = (md == 2'b01);
        end else m_t++;
      end
      2: if (md == 2'b10) m_t++; else model_enter(md);
      3: if (md == 2'b11) m_t = 0; else model_enter(md);
      default: model_enter(md);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs;
    logic e_r, e_a, e_g, e_d, lit;
    logic [1:0] e_p;
    int len;
    e_r = 0; e_a = 0; e_g = 0; e_d = 0; e_p = 2'd0;
    if (m_kind == 1) begin
      len = plen(m_ph, m_night);
      lit = (m_t < len - 3) || (m_t == len - 2);
      e_p = 2'(m_ph);
      e_r = lit && (m_ph == 0);
      e_g = lit && (m_ph == 1);
      e_a = lit && (m_ph == 2);
      e_d = (m_t == len - 1);
    end else if (m_kind == 2) begin
      e_a = ((m_t / FT) % 2) == 0;
      e_p = 2'd3;
    end else if (m_kind == 3) begin
      e_r = 1'b1;
      e_p = 2'd3;
    end
    chk("red", 32'(red), 32'(e_r));
    chk("amber", 32'(amber), 32'(e_a));
    chk("green", 32'(green), 32'(e_g));
    chk("phase", 32'(phase), 32'(e_p));
    chk("phase_done", 32'(phase_done), 32'(e_d));
    chk("at_most_one_lamp", 32'(int'(red) + int'(amber) + int'(green) <= 1), 32'd1);
  endtask

  task automatic step;
    @(posedge clock);
    if (reset_n) model_edge(mode);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset;
    reset_n = 1'b0;
    #2;
    m_kind = 0; m_ph = 0; m_t = 0; m_night = 1'b0;
    chk("async_reset_zero", 32'({red, amber, green, phase, phase_done}), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rv;
    logic [5:0] av;
    int k, len;
    bit found;

    // Reset state
    reset_n = 1'b0;
    mode    = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", 32'({red, amber, green, phase, phase_done}), 32'd0);
    reset_n = 1'b1;

    // Day sequence from reset release: red blink pattern and 18-cycle period
    rv = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rv[i] = red;
      if (i == 7) chk("done_at_red_c7", 32'(phase_done), 32'd1);
    end
    chk("red_pattern_day", 32'(rv), 32'h5F);
    for (int i = 8; i < 18; i++) step();
    step();
    chk("cycle_len_18", 32'({red, phase}), 32'({1'b1, 2'd0}));

    // Day -> night requested during GREEN
    k = 0;
    while (phase != 2'd1 && k < 40) begin step(); k++; end
    chk("reach_green", 32'(phase), 32'd1);
    mode = 2'b01;
    k = 0;
    while (phase != 2'd0 && k < 40) begin step(); k++; end
    len = 0;
    while (phase == 2'd0 && len < 40) begin step(); len++; end
    chk("night_red_len", 32'(len), 32'd5);
    len = 0;
    while (phase == 2'd1 && len < 40) begin step(); len++; end
    chk("night_green_len", 32'(len), 32'd4);

    // Amber flash requested mid-RED
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = (m_kind == 1 && m_ph == 0 && m_t == 2);
    end
    chk("reach_mid_red", 32'(found), 32'd1);
    mode = 2'b10;
    av = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      av[i] = amber;
      if (i == 0) chk("flash_entry", 32'({red, amber, phase}), 32'({1'b0, 1'b1, 2'd3}));
    end
    chk("flash_pattern", 32'(av), 32'h33);

    // All-red then back to day: full 8-cycle RED from cnt 0
    mode = 2'b11;
    repeat (5) step();
    mode = 2'b00;
    rv = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rv[i] = red;
      if (i == 7) chk("done_after_allred", 32'(phase_done), 32'd1);
    end
    chk("red_pattern_exit", 32'(rv), 32'h5F);

    // Asynchronous reset at GREEN cnt 3
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      found = (m_kind == 1 && m_ph == 1 && m_t == 3);
    end
    chk("reach_green_c3", 32'(found), 32'd1);
    do_reset();
    step();
    chk("restart_red", 32'({red, phase}), 32'({1'b1, 2'd0}));
    repeat (4) step();

    // Random mode changes with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
